// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, PC select and
// forwarding source codes.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_EXC      = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_EXC = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding select for one EX source register; the MEM-stage result
// takes priority over the older WB-stage result.
module pipe_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_rw,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rw,
  input  logic       wb_regwr,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (mem_regwr && (mem_rw != 5'd0) && (mem_rw == src)) begin
      fwd = FWD_MEM;
    end else if (wb_regwr && (wb_rw != 5'd0) && (wb_rw == src)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect sequencing, memory-wait timeout,
// exception entry, operand forwarding and stall statistics. State updates on the falling edge.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rw,
  input  logic        ex_regwr,
  input  logic        ex_memtoreg,
  input  logic [4:0]  mem_rw,
  input  logic        mem_regwr,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        mem_jump,
  input  logic        mem_overflow,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic [4:0]  wb_rw,
  input  logic        wb_regwr,
  input  logic        exc_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  pc_sel,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        exc_pending,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic              set_exc, set_timeout;
  logic              exc_ev, mem_stall, redirect, load_use;

  assign exc_ev    = mem_overflow & mem_regwr;
  assign mem_stall = mem_req & ~mem_ready;
  assign redirect  = mem_jump | (mem_branch & mem_zero);
  assign load_use  = ex_memtoreg & ex_regwr & (ex_rw != 5'd0) &
                     ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));
  assign wcnt_inc  = wcnt + WCNT_ONE;

  pipe_fwd_unit u_fwd_a (
    .src       (id_rs),
    .mem_rw    (mem_rw),
    .mem_regwr (mem_regwr),
    .wb_rw     (wb_rw),
    .wb_regwr  (wb_regwr),
    .fwd       (fwd_a)
  );

  pipe_fwd_unit u_fwd_b (
    .src       (id_rt),
    .mem_rw    (mem_rw),
    .mem_regwr (mem_regwr),
    .wb_rw     (wb_rw),
    .wb_regwr  (wb_regwr),
    .fwd       (fwd_b)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    set_exc     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_RUN: begin
        if (exc_ev) begin
          state_nxt = ST_EXC;
          set_exc   = 1'b1;
        end else if (mem_stall) begin
          state_nxt = ST_MEM_WAIT;
          wcnt_nxt  = WCNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = ST_RUN;
          wcnt_nxt  = '0;
        end else if (wcnt_inc >= WCNT_MAX) begin
          // Forced release: memory never answered within the allowed window.
          state_nxt   = ST_RUN;
          wcnt_nxt    = '0;
          set_timeout = 1'b1;
        end else begin
          wcnt_nxt = wcnt_inc;
        end
      end
      ST_EXC:  state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = SEL_SEQ;
    case (state)
      ST_RUN: begin
        if (exc_ev) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          pc_sel      = SEL_EXC;
        end else if (mem_stall) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
        end else if (redirect) begin
          // The redirect flushes the dependent instruction, so any load-use stall is moot.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          pc_sel      = mem_jump ? SEL_J : SEL_BR;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
        end
      end
      ST_EXC:  ifid_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      wcnt        <= '0;
      stall_cnt   <= 16'd0;
      exc_pending <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      wcnt <= wcnt_nxt;
      if (!pc_en) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
      if (set_exc) begin
        exc_pending <= 1'b1;
      end else if (exc_ack) begin
        exc_pending <= 1'b0;
      end
      if (set_timeout) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic, all
// checked against a rule-level reference model of the hazard controller.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rw, mem_rw, wb_rw;
  logic        id_uses_rt, ex_regwr, ex_memtoreg, mem_regwr, wb_regwr;
  logic        mem_branch, mem_zero, mem_jump, mem_overflow, mem_req, mem_ready, exc_ack;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  pc_sel, fwd_a, fwd_b;
  logic        exc_pending, mem_timeout;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_exc, m_wait, m_pend, m_tmo;
  int m_wcnt, m_stall;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw), .mem_regwr(mem_regwr),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .mem_overflow(mem_overflow), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rw(wb_rw), .wb_regwr(wb_regwr), .exc_ack(exc_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exc_pending(exc_pending), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (mem_regwr && mem_rw != 0 && mem_rw == src) return 2'b01;
    if (wb_regwr && wb_rw != 0 && wb_rw == src) return 2'b10;
    return 2'b00;
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, pc_sel}
  function automatic logic [8:0] ref_ctrl();
    logic pe, fe, de, me, ff, df, mf;
    logic [1:0] sel;
    logic lu;
    pe = 1; fe = 1; de = 1; me = 1; ff = 0; df = 0; mf = 0; sel = 2'b00;
    lu = ex_memtoreg && ex_regwr && ex_rw != 0 &&
         (ex_rw == id_rs || (id_uses_rt && ex_rw == id_rt));
    if (m_exc) ff = 1;
    else if (m_wait) begin
      if (!mem_ready) begin pe = 0; fe = 0; de = 0; me = 0; end
    end
    else if (mem_overflow && mem_regwr) begin ff = 1; df = 1; mf = 1; sel = 2'b11; end
    else if (mem_req && !mem_ready) begin pe = 0; fe = 0; de = 0; me = 0; end
    else if (mem_jump || (mem_branch && mem_zero)) begin
      ff = 1; df = 1; mf = 1; sel = mem_jump ? 2'b10 : 2'b01;
    end
    else if (lu) begin pe = 0; fe = 0; df = 1; end
    return {pe, fe, de, me, ff, df, mf, sel};
  endfunction

  task automatic model_edge(input logic pe);
    bit run;
    run = !m_exc && !m_wait;
    if (rst) begin
      m_exc = 0; m_wait = 0; m_wcnt = 0; m_pend = 0; m_tmo = 0; m_stall = 0;
      return;
    end
    if (!pe && m_stall < 65535) m_stall++;
    if (run && mem_overflow && mem_regwr) m_pend = 1;
    else if (exc_ack) m_pend = 0;
    if (m_exc) m_exc = 0;
    else if (m_wait) begin
      if (mem_ready) m_wait = 0;
      else begin
        m_wcnt++;
        if (m_wcnt >= TMO) begin m_wait = 0; m_tmo = 1; end
      end
    end
    else if (mem_overflow && mem_regwr) m_exc = 1;
    else if (mem_req && !mem_ready) begin m_wait = 1; m_wcnt = 1; end
  endtask

  // One clock: check combinational outputs mid-cycle, then sticky state after the falling edge.
  task automatic step();
    logic [8:0] exp_c;
    @(posedge clk);
    exp_c = ref_ctrl();
    chk("ctrl", 16'({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, pc_sel}),
        16'(exp_c));
    chk("fwd_a", 16'(fwd_a), 16'(ref_fwd(id_rs)));
    chk("fwd_b", 16'(fwd_b), 16'(ref_fwd(id_rt)));
    @(negedge clk);
    model_edge(exp_c[8]);
    #1;
    chk("flags", 16'({exc_pending, mem_timeout}), 16'({m_pend, m_tmo}));
    chk("stall_cnt", stall_cnt, 16'(m_stall));
  endtask

  task automatic idle();
    rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rw = 0; ex_regwr = 0; ex_memtoreg = 0;
    mem_rw = 0; mem_regwr = 0; mem_branch = 0; mem_zero = 0; mem_jump = 0; mem_overflow = 0;
    mem_req = 0; mem_ready = 0; wb_rw = 0; wb_regwr = 0; exc_ack = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    m_exc = 0; m_wait = 0; m_wcnt = 0; m_pend = 0; m_tmo = 0; m_stall = 0;
    rst = 0;
    step();
    chk("reset_stall_cnt", stall_cnt, 16'd0);

    // forwarding priority
    mem_rw = 5; wb_rw = 5; mem_regwr = 1; wb_regwr = 1; id_rs = 5; id_rt = 5;
    step();
    chk("fwd_mem_prio", 16'(fwd_a), 16'd1);
    mem_rw = 0; step();
    chk("fwd_wb", 16'(fwd_a), 16'd2);
    wb_rw = 0; step();
    chk("fwd_rf", 16'(fwd_a), 16'd0);

    // load-use stall for one cycle
    idle(); ex_memtoreg = 1; ex_regwr = 1; ex_rw = 8; id_rs = 8;
    step();
    idle(); step();
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    // load-use through rt
    ex_memtoreg = 1; ex_regwr = 1; ex_rw = 9; id_rt = 9; id_uses_rt = 1;
    step();
    idle(); step();

    // branch coinciding with load-use
    ex_memtoreg = 1; ex_regwr = 1; ex_rw = 8; id_rs = 8; mem_branch = 1; mem_zero = 1;
    step();
    mem_jump = 1; step();
    idle(); step();

    // memory wait of four cycles
    mem_req = 1; mem_ready = 0;
    repeat (4) step();
    mem_ready = 1; step();
    idle(); step();
    chk("wait_stall_cnt", stall_cnt, 16'd6);

    // memory timeout
    mem_req = 1; mem_ready = 0;
    repeat (TMO) step();
    chk("timeout_flag", 16'(mem_timeout), 16'd1);
    idle(); step();

    // exception with simultaneous jump
    mem_overflow = 1; mem_regwr = 1; mem_jump = 1; mem_rw = 3;
    step();
    chk("exc_pending_set", 16'(exc_pending), 16'd1);
    idle(); step();
    step();
    exc_ack = 1; step();
    chk("exc_pending_clr", 16'(exc_pending), 16'd0);
    // set beats simultaneous ack
    mem_overflow = 1; mem_regwr = 1; exc_ack = 1; mem_rw = 4;
    step();
    idle(); step();
    exc_ack = 1; step();
    idle();

    // reset during memory wait
    mem_req = 1; mem_ready = 0;
    step(); step();
    rst = 1; step();
    idle(); step();
    chk("rst_mid_wait_stall", stall_cnt, 16'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(99) == 0);
      id_rs        = 5'($urandom_range(7));
      id_rt        = 5'($urandom_range(7));
      id_uses_rt   = 1'($urandom_range(1));
      ex_rw        = 5'($urandom_range(7));
      ex_regwr     = 1'($urandom_range(1));
      ex_memtoreg  = 1'($urandom_range(1));
      mem_rw       = 5'($urandom_range(7));
      mem_regwr    = 1'($urandom_range(1));
      wb_rw        = 5'($urandom_range(7));
      wb_regwr     = 1'($urandom_range(1));
      mem_branch   = 1'($urandom_range(1));
      mem_zero     = 1'($urandom_range(1));
      mem_jump     = ($urandom_range(3) == 0);
      mem_overflow = ($urandom_range(7) == 0);
      mem_req      = ($urandom_range(3) == 0);
      mem_ready    = (i < 300) ? 1'($urandom_range(1)) : ($urandom_range(19) == 0);
      exc_ack      = ($urandom_range(3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
